// File: rtl/fc_pkg.sv
// fc_pkg: shared definitions for the fully-connected layer sequencer.
//   - fc_state_e : sequencer state encoding
//   - FC_*       : default width / size constants
//   - fc_cnt_w   : counter width able to index 0..n-1 (minimum 1 bit)
//   - fc_waddr_w : weight address width for an ni x no weight matrix
package fc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    DRAIN   = 3'd3,
    OUTPUT  = 3'd4
  } fc_state_e;

  localparam int FC_AXI_BUS_WIDTH = 32;
  localparam int FC_DATA_WIDTH    = 16;
  localparam int FC_ACC_WIDTH     = 32;
  localparam int FC_NUM_INPUTS    = 64;
  localparam int FC_NUM_OUTPUTS   = 10;

  function automatic int fc_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int fc_waddr_w(input int ni, input int no);
    return fc_cnt_w(ni * no);
  endfunction

endpackage

// File: rtl/fc_act_buffer.sv
// fc_act_buffer: NUM_INPUTS x DATA_WIDTH activation store.
//   clk, rst         : clock, async active-high reset (read register only)
//   wr_en/addr/data  : single write port
//   rd_en/addr       : read request
//   rd_data          : registered read data, valid one cycle after rd_en;
//                      this latency matches the weight ROM so activation
//                      and weight reach the MAC in the same cycle.
module fc_act_buffer
  import fc_pkg::*;
#(
  parameter int  NUM_INPUTS = FC_NUM_INPUTS,
  parameter int  DATA_WIDTH = FC_DATA_WIDTH,
  localparam int AW         = fc_cnt_w(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [NUM_INPUTS];
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage is never reset: contents persist until overwritten.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_comb begin
    rd_data_d = rd_en ? mem_q[rd_addr] : rd_data_q;
  end

  // Read stage boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: sequencer for one fully-connected layer.
// Buffers one activation frame from the AXI4-Stream slave, then for each
// output neuron streams weights (1-cycle ROM) and buffered activations into
// an external MAC and emits the accumulated result on the AXI4-Stream master.
//   axi_clk, axi_reset           : clock, async active-high reset
//   s_axis_*                     : activation input (keep ignored)
//   weight_rd_en, weight_addr    : weight ROM read, addr = n*NUM_INPUTS + i
//   mac_en, mac_clr, mac_act     : MAC control, aligned with ROM data
//   mac_acc                      : MAC accumulator
//   m_axis_*                     : one result per neuron, last on final one
//   busy                         : in COMPUTE, DRAIN or OUTPUT
//   err_len                      : sticky frame-length error
// Build option: FC_RELU_EN clamps negative results to zero.
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int  AXI_BUS_WIDTH = FC_AXI_BUS_WIDTH,
  parameter int  DATA_WIDTH    = FC_DATA_WIDTH,
  parameter int  ACC_WIDTH     = FC_ACC_WIDTH,
  parameter int  NUM_INPUTS    = FC_NUM_INPUTS,
  parameter int  NUM_OUTPUTS   = FC_NUM_OUTPUTS,
  localparam int WADDR_WIDTH   = fc_waddr_w(NUM_INPUTS, NUM_OUTPUTS)
) (
  input  logic                     axi_clk,
  input  logic                     axi_reset,
  input  logic                     s_axis_valid,
  input  logic [AXI_BUS_WIDTH-1:0] s_axis_data,
  output logic                     s_axis_ready,
  input  logic                     s_axis_last,
  input  logic [3:0]               s_axis_keep,
  output logic                     weight_rd_en,
  output logic [WADDR_WIDTH-1:0]   weight_addr,
  output logic                     mac_en,
  output logic                     mac_clr,
  output logic [DATA_WIDTH-1:0]    mac_act,
  input  logic [ACC_WIDTH-1:0]     mac_acc,
  output logic                     m_axis_valid,
  output logic [AXI_BUS_WIDTH-1:0] m_axis_data,
  input  logic                     m_axis_ready,
  output logic                     m_axis_last,
  output logic                     busy,
  output logic                     err_len
);

  localparam int IW = fc_cnt_w(NUM_INPUTS);
  localparam int NW = fc_cnt_w(NUM_OUTPUTS);

  fc_state_e state_q, state_d;

  logic                     arm_q, arm_d;
  logic [IW-1:0]            in_cnt_q, in_cnt_d;
  logic [IW-1:0]            i_cnt_q, i_cnt_d;
  logic [NW-1:0]            n_cnt_q, n_cnt_d;
  logic [WADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic                     drain_q, drain_d;
  logic                     err_len_q, err_len_d;
  logic [AXI_BUS_WIDTH-1:0] result_q, result_d;
  logic                     mac_en_p1_q, mac_en_p1_d;
  logic                     mac_clr_p1_q, mac_clr_p1_d;

  logic s_hs, m_hs, last_in, last_i, last_n, last_w;
  logic unused_bits;

  assign unused_bits = ^{s_axis_keep, s_axis_data[AXI_BUS_WIDTH-1:DATA_WIDTH]};

  assign s_hs    = (state_q == LOAD) && s_axis_valid;
  assign m_hs    = (state_q == OUTPUT) && m_axis_ready;
  assign last_in = (in_cnt_q == IW'(NUM_INPUTS - 1));
  assign last_i  = (i_cnt_q == IW'(NUM_INPUTS - 1));
  assign last_n  = (n_cnt_q == NW'(NUM_OUTPUTS - 1));
  assign last_w  = (waddr_q == WADDR_WIDTH'(NUM_INPUTS * NUM_OUTPUTS - 1));

  // Result capture: optional ReLU, then sign-extend or truncate to the bus.
  function automatic logic [AXI_BUS_WIDTH-1:0] fc_capture(
    input logic signed [ACC_WIDTH-1:0] acc
  );
`ifdef FC_RELU_EN
    if (acc[ACC_WIDTH-1]) return '0;
`endif
    return AXI_BUS_WIDTH'(acc);
  endfunction

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // IDLE waits for arm_q so LOAD begins on the second edge after reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arm_q) state_d = LOAD;
      LOAD:    if (s_hs && last_in) state_d = COMPUTE;
      COMPUTE: if (last_i) state_d = DRAIN;
      DRAIN:   if (drain_q) state_d = OUTPUT;
      OUTPUT:  if (m_hs) state_d = last_n ? LOAD : COMPUTE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis_ready = 1'b0;
    weight_rd_en = 1'b0;
    weight_addr  = '0;
    m_axis_valid = 1'b0;
    m_axis_last  = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      LOAD:    s_axis_ready = 1'b1;
      COMPUTE: begin
        weight_rd_en = 1'b1;
        weight_addr  = waddr_q;
        busy         = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      OUTPUT:  begin
        m_axis_valid = 1'b1;
        m_axis_last  = last_n;
        busy         = 1'b1;
      end
      default: ;
    endcase
  end

  // Weight addresses run sequentially across neurons, so a single counter
  // tracks n*NUM_INPUTS + i without a multiplier.
  always_comb begin
    arm_d        = 1'b1;
    in_cnt_d     = in_cnt_q;
    i_cnt_d      = i_cnt_q;
    n_cnt_d      = n_cnt_q;
    waddr_d      = waddr_q;
    drain_d      = 1'b0;
    err_len_d    = err_len_q;
    result_d     = result_q;
    mac_en_p1_d  = (state_q == COMPUTE);
    mac_clr_p1_d = (state_q == COMPUTE) && (i_cnt_q == '0);
    unique case (state_q)
      LOAD: begin
        if (s_hs) begin
          if (last_in) begin
            in_cnt_d = '0;
            i_cnt_d  = '0;
            n_cnt_d  = '0;
            waddr_d  = '0;
            if (!s_axis_last) err_len_d = 1'b1;
          end else if (s_axis_last) begin
            in_cnt_d  = '0;
            err_len_d = 1'b1;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      COMPUTE: begin
        i_cnt_d = last_i ? '0 : i_cnt_q + 1'b1;
        waddr_d = last_w ? '0 : waddr_q + 1'b1;
      end
      DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) result_d = fc_capture(mac_acc);
      end
      OUTPUT: begin
        if (m_hs && !last_n) n_cnt_d = n_cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  // ROM-read stage boundary: MAC controls follow the read by one cycle
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      arm_q        <= 1'b0;
      in_cnt_q     <= '0;
      i_cnt_q      <= '0;
      n_cnt_q      <= '0;
      waddr_q      <= '0;
      drain_q      <= 1'b0;
      err_len_q    <= 1'b0;
      result_q     <= '0;
      mac_en_p1_q  <= 1'b0;
      mac_clr_p1_q <= 1'b0;
    end else begin
      arm_q        <= arm_d;
      in_cnt_q     <= in_cnt_d;
      i_cnt_q      <= i_cnt_d;
      n_cnt_q      <= n_cnt_d;
      waddr_q      <= waddr_d;
      drain_q      <= drain_d;
      err_len_q    <= err_len_d;
      result_q     <= result_d;
      mac_en_p1_q  <= mac_en_p1_d;
      mac_clr_p1_q <= mac_clr_p1_d;
    end
  end

  fc_act_buffer #(
    .NUM_INPUTS (NUM_INPUTS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_act_buffer (
    .clk     (axi_clk),
    .rst     (axi_reset),
    .wr_en   (s_hs),
    .wr_addr (in_cnt_q),
    .wr_data (s_axis_data[DATA_WIDTH-1:0]),
    .rd_en   (state_q == COMPUTE),
    .rd_addr (i_cnt_q),
    .rd_data (mac_act)
  );

  assign mac_en      = mac_en_p1_q;
  assign mac_clr     = mac_clr_p1_q;
  assign m_axis_data = result_q;
  assign err_len     = err_len_q;

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Self-checking bench for fc_layer_sequencer with NUM_INPUTS=4,
// NUM_OUTPUTS=2, a 1-cycle weight ROM model and a behavioural MAC.
module tb_fc_layer_sequencer;

  logic        axi_clk = 1'b0;
  logic        axi_reset = 1'b0;
  logic        s_axis_valid = 1'b0;
  logic [31:0] s_axis_data = '0;
  logic        s_axis_ready;
  logic        s_axis_last = 1'b0;
  logic [3:0]  s_axis_keep = 4'hF;
  logic        weight_rd_en;
  logic [2:0]  weight_addr;
  logic        mac_en;
  logic        mac_clr;
  logic signed [15:0] mac_act;
  logic signed [31:0] acc = '0;
  logic        m_axis_valid;
  logic [31:0] m_axis_data;
  logic        m_axis_ready = 1'b1;
  logic        m_axis_last;
  logic        busy;
  logic        err_len;

  always #5 axi_clk = ~axi_clk;

  fc_layer_sequencer #(
    .AXI_BUS_WIDTH (32),
    .DATA_WIDTH    (16),
    .ACC_WIDTH     (32),
    .NUM_INPUTS    (4),
    .NUM_OUTPUTS   (2)
  ) dut (
    .axi_clk      (axi_clk),
    .axi_reset    (axi_reset),
    .s_axis_valid (s_axis_valid),
    .s_axis_data  (s_axis_data),
    .s_axis_ready (s_axis_ready),
    .s_axis_last  (s_axis_last),
    .s_axis_keep  (s_axis_keep),
    .weight_rd_en (weight_rd_en),
    .weight_addr  (weight_addr),
    .mac_en       (mac_en),
    .mac_clr      (mac_clr),
    .mac_act      (mac_act),
    .mac_acc      (acc),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_ready (m_axis_ready),
    .m_axis_last  (m_axis_last),
    .busy         (busy),
    .err_len      (err_len)
  );

  // Weight ROM and MAC environment
  logic signed [15:0] rom [8] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4,
                                  -16'sd1, -16'sd1, -16'sd1, -16'sd1};
  logic signed [15:0] rom_q = '0;

  always @(posedge axi_clk) begin
    if (weight_rd_en) rom_q <= rom[weight_addr];
    if (mac_en) acc <= mac_clr ? $signed(mac_act) * $signed(rom_q)
                               : acc + $signed(mac_act) * $signed(rom_q);
  end

  // Monitor: samples just before each rising edge
  int cyc = 0;
  always @(posedge axi_clk) cyc <= cyc + 1;

  int   out_q [$];
  logic last_q [$];
  int   rd_q [$];
  int   vrise_q [$];
  int   hs_cyc = 0;
  logic prev_v = 1'b0;
  logic prev_rd = 1'b0;

  always begin
    @(negedge axi_clk);
    #4;
    if (!axi_reset) begin
      if (m_axis_valid && m_axis_ready) begin
        out_q.push_back(int'(m_axis_data));
        last_q.push_back(m_axis_last);
      end
      if (m_axis_valid && !prev_v) vrise_q.push_back(cyc);
      if (weight_rd_en && !prev_rd) rd_q.push_back(cyc);
      if (s_axis_valid && s_axis_ready) hs_cyc = cyc;
    end
    prev_v  = m_axis_valid;
    prev_rd = weight_rd_en;
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting, expected event", name);
  endtask

  function automatic int relu_exp(input int x);
`ifdef FC_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  typedef struct {
    logic [3:0][15:0] act;
    logic [3:0]       last;
    int               nbeats;
    int               exp_n;
    int               exp0;
    int               exp1;
    logic             exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic set_vec(input int k, input int a0, input int a1, input int a2,
                         input int a3, input logic [3:0] last, input int nbeats,
                         input int exp_n, input int e0, input int e1,
                         input logic err);
    vecs[k].act[0]  = 16'(a0);
    vecs[k].act[1]  = 16'(a1);
    vecs[k].act[2]  = 16'(a2);
    vecs[k].act[3]  = 16'(a3);
    vecs[k].last    = last;
    vecs[k].nbeats  = nbeats;
    vecs[k].exp_n   = exp_n;
    vecs[k].exp0    = e0;
    vecs[k].exp1    = e1;
    vecs[k].exp_err = err;
  endtask

  task automatic clear_queues();
    out_q.delete();
    last_q.delete();
    rd_q.delete();
    vrise_q.delete();
  endtask

  // Called at a falling edge; returns at the falling edge after the handshake.
  task automatic send_beat(input logic [31:0] data, input logic last);
    int t = 0;
    s_axis_valid = 1'b1;
    s_axis_data  = data;
    s_axis_last  = last;
    while (!s_axis_ready && t < 100) begin
      @(negedge axi_clk);
      t++;
    end
    if (!s_axis_ready) timeout_fail("s_axis_ready");
    @(negedge axi_clk);
    s_axis_valid = 1'b0;
    s_axis_last  = 1'b0;
  endtask

  task automatic wait_outs(input int n, input int budget);
    int t = 0;
    while (out_q.size() < n && t < budget) begin
      @(negedge axi_clk);
      t++;
    end
    if (out_q.size() < n) timeout_fail("m_axis_beats");
  endtask

  task automatic run_vec(input int k);
    vec_t v = vecs[k];
    clear_queues();
    for (int b = 0; b < v.nbeats; b++)
      send_beat({16'hA5C3, v.act[b]}, v.last[b]);
    if (v.exp_n > 0) wait_outs(v.exp_n, 200);
    else repeat (12) @(negedge axi_clk);
    chk($sformatf("v%0d_nout", k), out_q.size(), v.exp_n);
    chk($sformatf("v%0d_err_len", k), err_len, v.exp_err);
    if (v.exp_n == 0) begin
      chk($sformatf("v%0d_ready_in_load", k), s_axis_ready, 1);
      chk($sformatf("v%0d_busy", k), busy, 0);
    end else if (out_q.size() == 2 && rd_q.size() >= 1 && vrise_q.size() >= 2) begin
      chk($sformatf("v%0d_data0", k), out_q[0], relu_exp(v.exp0));
      chk($sformatf("v%0d_last0", k), last_q[0], 0);
      chk($sformatf("v%0d_data1", k), out_q[1], relu_exp(v.exp1));
      chk($sformatf("v%0d_last1", k), last_q[1], 1);
      chk($sformatf("v%0d_hs_to_rd", k), rd_q[0] - hs_cyc, 1);
      chk($sformatf("v%0d_rd_to_valid", k), vrise_q[0] - rd_q[0], 6);
      chk($sformatf("v%0d_neuron_period", k), vrise_q[1] - vrise_q[0], 7);
    end else begin
      timeout_fail($sformatf("v%0d_results", k));
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_ctrl"}, {s_axis_ready, weight_rd_en, mac_en, mac_clr,
                          m_axis_valid, m_axis_last, busy, err_len}, 0);
    chk({name, "_data"}, {weight_addr, mac_act, m_axis_data}, 0);
  endtask

  initial begin
    int t;
    set_vec(0, 1, 2, 3, 4,           4'b1000, 4, 2, 30, -10, 1'b0);
    set_vec(1, 5, 6, 0, 0,           4'b0010, 2, 0, 0, 0, 1'b1);
    set_vec(2, 1, 2, 3, 4,           4'b1000, 4, 2, 30, -10, 1'b1);
    set_vec(3, 1, 2, 3, 4,           4'b0000, 4, 2, 30, -10, 1'b1);
    set_vec(4, -1, 0, 2, -3,         4'b1000, 4, 2, -7, 2, 1'b1);
    set_vec(5, 32767, 32767, 32767, 32767, 4'b1000, 4, 2, 327670, -131068, 1'b1);
    set_vec(6, 100, -50, 25, 7,      4'b1000, 4, 2, 103, -82, 1'b1);

    // Reset state and release timing
    #1 axi_reset = 1'b1;
    #12;
    chk_all_zero("reset");
    @(negedge axi_clk);
    axi_reset = 1'b0;
    @(negedge axi_clk);
    chk("ready_after_edge1", s_axis_ready, 0);
    @(negedge axi_clk);
    chk("ready_after_edge2", s_axis_ready, 1);

    // Table-driven frames
    for (int k = 0; k < 7; k++) run_vec(k);

    // Backpressure on result 0
    clear_queues();
    m_axis_ready = 1'b0;
    for (int b = 0; b < 4; b++) send_beat(32'(b + 1), b == 3);
    t = 0;
    while (!m_axis_valid && t < 100) begin
      @(negedge axi_clk);
      t++;
    end
    if (!m_axis_valid) timeout_fail("stall_valid");
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("stall%0d_valid", s), m_axis_valid, 1);
      chk($sformatf("stall%0d_data", s), int'(m_axis_data), relu_exp(30));
      chk($sformatf("stall%0d_rd_en", s), weight_rd_en, 0);
      @(negedge axi_clk);
    end
    m_axis_ready = 1'b1;
    wait_outs(2, 200);
    chk("stall_nout", out_q.size(), 2);
    if (out_q.size() == 2) begin
      chk("stall_data0", out_q[0], relu_exp(30));
      chk("stall_data1", out_q[1], relu_exp(-10));
      chk("stall_last1", last_q[1], 1);
    end

    // Reset during COMPUTE of neuron 1
    clear_queues();
    for (int b = 0; b < 4; b++) send_beat(32'(b + 1), b == 3);
    wait_outs(1, 200);
    t = 0;
    while (!weight_rd_en && t < 20) begin
      @(negedge axi_clk);
      t++;
    end
    if (!weight_rd_en) timeout_fail("neuron1_compute");
    @(negedge axi_clk);
    #2 axi_reset = 1'b1;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(negedge axi_clk);
    axi_reset = 1'b0;
    @(negedge axi_clk);
    chk("midreset_ready_edge1", s_axis_ready, 0);
    @(negedge axi_clk);
    chk("midreset_ready_edge2", s_axis_ready, 1);
    repeat (20) @(negedge axi_clk);
    chk("midreset_no_partial", out_q.size(), 1);
    chk("midreset_valid", m_axis_valid, 0);

    // Normal operation after the abort (err_len cleared by reset)
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
